io_bus_arbiter: RTL and testbench

- Shares the single bit-serial IO block between two requesters: the CPU port (MC14500B core) and a host/debug port.
- Sequences every IO access as setup, access, release. The IO block latches writes on the rising edge of its write input, so the strobe is generated here, registered and glitch-free.
- Sits between the CPU, the host interface and the IO block; it is the only driver of the IO block's write, data_in and address inputs.

---
 rtl/io_bus_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the bit-serial IO block between the CPU port and the
// host/debug port. Each access runs setup -> access -> release, so io_write is
// a clean registered pulse that sits between stable address/data phases.
// Optional build macro: IO_ARB_RANGE_CHECK_EN adds cpu_err/host_err and lets
// illegal accesses skip the IO block entirely.
module io_bus_arbiter #(
    parameter int ADDR_WIDTH  = 4,
    parameter int OUTPUT_SIZE = 4,
    parameter int INPUT_SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_wdata,
    output logic                  cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic                  host_wdata,
    output logic                  host_rdata,
    output logic                  host_ack,
    output logic                  io_write,
    output logic                  io_data_in,
    output logic [ADDR_WIDTH-1:0] io_address,
    input  logic                  io_data_out
`ifdef IO_ARB_RANGE_CHECK_EN
    ,
    output logic                  cpu_err,
    output logic                  host_err
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_ACCESS  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic                  io_write_q, io_write_d;
    logic                  io_data_in_q, io_data_in_d;
    logic [ADDR_WIDTH-1:0] io_address_q, io_address_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  host_ack_q, host_ack_d;
    logic                  cpu_rdata_q, cpu_rdata_d;
    logic                  host_rdata_q, host_rdata_d;

    logic                  pick;
    logic                  sel_we;
    logic                  sel_wdata;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  illegal;

`ifdef IO_ARB_RANGE_CHECK_EN
    logic cpu_err_q, cpu_err_d;
    logic host_err_q, host_err_d;

    // Writes may only target output latches; reads may only target input pins.
    function automatic logic access_illegal(input logic we, input logic [ADDR_WIDTH-1:0] addr);
        int a;
        a = int'({{(32-ADDR_WIDTH){1'b0}}, addr});
        if (we) return (a >= OUTPUT_SIZE);
        return (a < OUTPUT_SIZE) || (a >= OUTPUT_SIZE + INPUT_SIZE);
    endfunction
`endif

    // Next-state logic: arbitration in IDLE, then fixed setup/access/release sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        io_write_d   = 1'b0;
        io_data_in_d = io_data_in_q;
        io_address_d = io_address_q;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
`ifdef IO_ARB_RANGE_CHECK_EN
        cpu_err_d    = 1'b0;
        host_err_d   = 1'b0;
`endif
        pick      = PORT_CPU;
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        illegal   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || host_req) begin
                    // On a tie the port that did not win last time gets the bus.
                    pick = (host_req && (!cpu_req || last_grant_q == PORT_CPU)) ? PORT_HOST : PORT_CPU;
                    if (pick == PORT_HOST) begin
                        sel_we    = host_we;
                        sel_addr  = host_addr;
                        sel_wdata = host_wdata;
                    end
`ifdef IO_ARB_RANGE_CHECK_EN
                    illegal = access_illegal(sel_we, sel_addr);
`endif
                    gnt_d        = pick;
                    last_grant_d = pick;
                    we_d         = sel_we;
                    if (illegal) begin
                        // Illegal access never touches the IO block; answer immediately.
                        state_d = ST_RELEASE;
                        if (pick == PORT_HOST) begin
                            host_ack_d   = 1'b1;
                            host_rdata_d = 1'b0;
                        end else begin
                            cpu_ack_d    = 1'b1;
                            cpu_rdata_d  = 1'b0;
                        end
`ifdef IO_ARB_RANGE_CHECK_EN
                        if (pick == PORT_HOST) host_err_d = 1'b1;
                        else                   cpu_err_d  = 1'b1;
`endif
                    end else begin
                        io_address_d = sel_addr;
                        io_data_in_d = sel_wdata;
                        state_d      = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                io_write_d = we_q;
                state_d    = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    if (gnt_q == PORT_HOST) host_rdata_d = io_data_out;
                    else                    cpu_rdata_d  = io_data_out;
                end
                if (gnt_q == PORT_HOST) host_ack_d = 1'b1;
                else                    cpu_ack_d  = 1'b1;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_HOST;
            gnt_q        <= PORT_CPU;
            we_q         <= 1'b0;
            io_write_q   <= 1'b0;
            io_data_in_q <= 1'b0;
            io_address_q <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= 1'b0;
            host_rdata_q <= 1'b0;
`ifdef IO_ARB_RANGE_CHECK_EN
            cpu_err_q    <= 1'b0;
            host_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            io_write_q   <= io_write_d;
            io_data_in_q <= io_data_in_d;
            io_address_q <= io_address_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
`ifdef IO_ARB_RANGE_CHECK_EN
            cpu_err_q    <= cpu_err_d;
            host_err_q   <= host_err_d;
`endif
        end
    end

    assign io_write   = io_write_q;
    assign io_data_in = io_data_in_q;
    assign io_address = io_address_q;
    assign cpu_ack    = cpu_ack_q;
    assign host_ack   = host_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
`ifdef IO_ARB_RANGE_CHECK_EN
    assign cpu_err    = cpu_err_q;
    assign host_err   = host_err_q;
`endif

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Testbench for io_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_io_bus_arbiter;

    localparam int AW = 4;
    localparam int OS = 4;
    localparam int IS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_wdata;
    logic [AW-1:0] cpu_addr;
    logic          cpu_rdata, cpu_ack;
    logic          host_req, host_we, host_wdata;
    logic [AW-1:0] host_addr;
    logic          host_rdata, host_ack;
    logic          io_write, io_data_in;
    logic [AW-1:0] io_address;
    logic          io_data_out;
`ifdef IO_ARB_RANGE_CHECK_EN
    logic          cpu_err, host_err;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    io_bus_arbiter #(.ADDR_WIDTH(AW), .OUTPUT_SIZE(OS), .INPUT_SIZE(IS)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .io_write(io_write), .io_data_in(io_data_in), .io_address(io_address),
        .io_data_out(io_data_out)
`ifdef IO_ARB_RANGE_CHECK_EN
        , .cpu_err(cpu_err), .host_err(host_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    // Port 0 = CPU, port 1 = host. A granted transaction is tracked by the
    // number of cycles elapsed since its grant.
    bit          m_active = 0;
    int          m_age = 0;
    int          m_port = 0;
    int          m_last = 1;
    bit          m_we;
    bit          e_wr = 0, e_din = 0;
    bit [AW-1:0] e_addr = '0;
    bit [1:0]    e_ack = '0, e_rd = '0, e_err = '0;

    function automatic bit is_illegal(input bit we, input int a);
`ifdef IO_ARB_RANGE_CHECK_EN
        if (we) return a >= OS;
        return (a < OS) || (a >= OS + IS);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        bit [1:0] r;
        r = {host_req, cpu_req};
        if (reset) begin
            m_active = 0; m_last = 1;
            e_wr = 0; e_din = 0; e_addr = '0; e_ack = '0; e_rd = '0; e_err = '0;
        end else begin
            e_wr = 0; e_ack = '0; e_err = '0;
            if (m_active) begin
                m_age++;
                if (m_age == 2) e_wr = m_we;
                else if (m_age == 3) begin
                    e_ack[m_port] = 1'b1;
                    if (!m_we) e_rd[m_port] = io_data_out;
                end else if (m_age >= 4) m_active = 0;
            end else if (r != 2'b00) begin
                bit          w, d;
                bit [AW-1:0] a;
                if (r == 2'b11) m_port = 1 - m_last;
                else            m_port = r[1] ? 1 : 0;
                m_last = m_port;
                w = m_port ? host_we    : cpu_we;
                a = m_port ? host_addr  : cpu_addr;
                d = m_port ? host_wdata : cpu_wdata;
                m_we = w;
                m_active = 1;
                if (is_illegal(w, int'(a))) begin
                    m_age = 3;
                    e_ack[m_port] = 1'b1;
                    e_err[m_port] = 1'b1;
                    e_rd[m_port]  = 1'b0;
                end else begin
                    m_age  = 1;
                    e_addr = a;
                    e_din  = d;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("io_write",   io_write,   e_wr);
            check("io_data_in", io_data_in, e_din);
            check("io_address", io_address, e_addr);
            check("cpu_ack",    cpu_ack,    e_ack[0]);
            check("host_ack",   host_ack,   e_ack[1]);
            check("cpu_rdata",  cpu_rdata,  e_rd[0]);
            check("host_rdata", host_rdata, e_rd[1]);
`ifdef IO_ARB_RANGE_CHECK_EN
            check("cpu_err",    cpu_err,    e_err[0]);
            check("host_err",   host_err,   e_err[1]);
`endif
        end
    end

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = 0;
        io_data_out = 0;
        repeat (3) step();
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst io_write",   io_write,   0);
        check("rst io_address", io_address, 0);
        check("rst cpu_ack",    cpu_ack,    0);
        check("rst host_rdata", host_rdata, 0);

        // CPU write addr 2, data 1
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = 4'd2; cpu_wdata = 1;
        step(); cpu_req = 0;
        @(negedge clk);
        check("t1 addr N+1",  io_address, 2);
        check("t1 din N+1",   io_data_in, 1);
        check("t1 wr N+1",    io_write,   0);
        step(); @(negedge clk);
        check("t1 wr N+2",    io_write,   1);
        step(); @(negedge clk);
        check("t1 ack N+3",   cpu_ack,    1);
        check("t1 hack N+3",  host_ack,   0);
        check("t1 wr N+3",    io_write,   0);

        // Host read addr 5, drops request in SETUP, IO returns 1 during ACCESS
        step();
        host_req = 1; host_we = 0; host_addr = 4'd5;
        step(); host_req = 0;
        step(); io_data_out = 1;
        @(negedge clk);
        check("t2 wr ACCESS", io_write, 0);
        step(); io_data_out = 0;
        @(negedge clk);
        check("t2 hack N+3",  host_ack,   1);
        check("t2 hrdata",    host_rdata, 1);
        check("t2 cack N+3",  cpu_ack,    0);

        // Both request and hold: CPU, host, CPU, host, acks 4 cycles apart
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = 4'd1; cpu_wdata = 1;
        host_req = 1; host_we = 0; host_addr = 4'd6;
        for (int k = 1; k <= 16; k++) begin
            step(); @(negedge clk);
            check("t3 cpu_ack",  cpu_ack,  (k == 3 || k == 11) ? 1 : 0);
            check("t3 host_ack", host_ack, (k == 7 || k == 15) ? 1 : 0);
        end
        cpu_req = 0; host_req = 0;

        // Reset during ACCESS of a write, then a fresh request
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = 4'd3; cpu_wdata = 0;
        step(); cpu_req = 0;
        step(); reset = 1;
        @(negedge clk);
        check("t4 wr ACCESS", io_write, 1);
        step(); reset = 0;
        @(negedge clk);
        check("t4 wr after rst",   io_write,   0);
        check("t4 no ack",         cpu_ack,    0);
        check("t4 addr after rst", io_address, 0);
        host_req = 1; host_we = 1; host_addr = 4'd1; host_wdata = 1;
        step(); host_req = 0;
        @(negedge clk);
        check("t4 new addr", io_address, 1);
        step(); step(); @(negedge clk);
        check("t4 new hack", host_ack, 1);

`ifdef IO_ARB_RANGE_CHECK_EN
        // Illegal write and illegal read
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = 4'd6; cpu_wdata = 1;
        step(); cpu_req = 0;
        @(negedge clk);
        check("rc wr ack",  cpu_ack,    1);
        check("rc wr err",  cpu_err,    1);
        check("rc wr io",   io_write,   0);
        check("rc wr addr", io_address, 1);
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'd1;
        step(); cpu_req = 0;
        @(negedge clk);
        check("rc rd err",   cpu_err,   1);
        check("rc rd rdata", cpu_rdata, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            reset = ($urandom_range(0, 299) == 0);
            io_data_out = 1'($urandom);
            if (cpu_ack) cpu_req = ($urandom_range(0, 3) == 0);
            else if (!cpu_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    cpu_req = 1; cpu_we = 1'($urandom);
                    cpu_addr = AW'($urandom); cpu_wdata = 1'($urandom);
                end
            end else if ($urandom_range(0, 39) == 0) cpu_req = 0;
            if (host_ack) host_req = ($urandom_range(0, 3) == 0);
            else if (!host_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    host_req = 1; host_we = 1'($urandom);
                    host_addr = AW'($urandom); host_wdata = 1'($urandom);
                end
            end else if ($urandom_range(0, 39) == 0) host_req = 0;
        end
        step();
        reset = 0; cpu_req = 0; host_req = 0;
        repeat (6) step();
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
